// File: rtl/branch_flush_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_flush_ctrl_if
// Description : Pipeline-side signal bundle for the branch hazard controller.
//               The master side is the pipeline (drives hazard inputs). The
//               slave side is the controller (drives stall/flush/statistics).
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_flush_ctrl_if #(
  parameter int CNT_W = 16
);
  // Hazard inputs from the pipeline
  logic             branch_d;
  logic             flag_wr_e;
  logic             pc_src_e;
  logic             vec_busy;
  logic             clr_stats;

  // Pipeline control and profiling outputs
  logic             stall_f;
  logic             stall_d;
  logic             flush_d;
  logic             flush_e;
  logic [1:0]       state;
  logic [CNT_W-1:0] br_total;
  logic [CNT_W-1:0] br_taken;

  modport master (
    output branch_d, flag_wr_e, pc_src_e, vec_busy, clr_stats,
    input  stall_f, stall_d, flush_d, flush_e, state, br_total, br_taken
  );

  modport slave (
    input  branch_d, flag_wr_e, pc_src_e, vec_busy, clr_stats,
    output stall_f, stall_d, flush_d, flush_e, state, br_total, br_taken
  );
endinterface
`default_nettype wire

// File: rtl/branch_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_flush_ctrl
// Description : Branch-path hazard controller. Inserts a bubble behind a
//               flag-writing instruction, holds while the vector unit is
//               busy, and flushes wrong-path instructions after a taken
//               branch (predict-not-taken). Keeps saturating branch stats.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_flush_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  wire                  clk_i,
  input  wire                  rst_ni,
  branch_flush_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_HOLD    = 2'd1,
    S_RESOLVE = 2'd2,
    S_FLUSH   = 2'd3
  } state_t;

  // Counter only ever holds values up to FLUSH_CYCLES-1.
  localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES);
  localparam logic [FC_W-1:0]  FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [CNT_W-1:0] total_q, taken_q;
  logic             inc_total, inc_taken;

  // State and flush-counter registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Next-state and combinational pipeline controls
  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    bus.stall_f = 1'b0;
    bus.stall_d = 1'b0;
    bus.flush_d = 1'b0;
    bus.flush_e = 1'b0;
    inc_total   = 1'b0;
    inc_taken   = 1'b0;

    case (state_q)
      S_RUN: begin
        if (bus.vec_busy) begin
          bus.stall_f = 1'b1;
          bus.stall_d = 1'b1;
        end else if (bus.branch_d && bus.flag_wr_e) begin
          // One bubble lets the falling-edge flag write settle before the
          // branch reaches the condition unit.
          bus.stall_f = 1'b1;
          bus.stall_d = 1'b1;
          bus.flush_e = 1'b1;
          state_d     = S_HOLD;
        end else if (bus.branch_d) begin
          state_d = S_RESOLVE;
        end
      end

      S_HOLD: begin
        if (bus.vec_busy) begin
          bus.stall_f = 1'b1;
          bus.stall_d = 1'b1;
        end else begin
          state_d = S_RESOLVE;
        end
      end

      S_RESOLVE: begin
        // A branch sitting in Decode now is not latched: it is either
        // flushed (taken) or seen again in RUN (not taken).
        if (bus.vec_busy) begin
          bus.stall_f = 1'b1;
          bus.stall_d = 1'b1;
        end else if (bus.pc_src_e) begin
          bus.flush_d = 1'b1;
          bus.flush_e = 1'b1;
          fcnt_d      = FC_LOAD;
          inc_total   = 1'b1;
          inc_taken   = 1'b1;
          state_d     = (FLUSH_CYCLES <= 1) ? S_RUN : S_FLUSH;
        end else begin
          inc_total = 1'b1;
          state_d   = S_RUN;
        end
      end

      S_FLUSH: begin
        // Target fetch proceeds; wrong-path slots are cleared.
        bus.flush_d = 1'b1;
        bus.flush_e = 1'b1;
        fcnt_d      = fcnt_q - 1'b1;
        if (fcnt_q <= FC_W'(1)) begin
          state_d = S_RUN;
        end
      end

      default: state_d = S_RUN;
    endcase
  end

  // Saturating statistics counters; clear wins over a same-cycle increment
  always_ff @(posedge clk_i) begin
    if (!rst_ni || bus.clr_stats) begin
      total_q <= '0;
      taken_q <= '0;
    end else begin
      if (inc_total && (total_q != CNT_MAX)) begin
        total_q <= total_q + 1'b1;
      end
      if (inc_taken && (taken_q != CNT_MAX)) begin
        taken_q <= taken_q + 1'b1;
      end
    end
  end

  assign bus.state    = state_q;
  assign bus.br_total = total_q;
  assign bus.br_taken = taken_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_flush_ctrl
// Description : Directed bench for branch_flush_ctrl (FLUSH_CYCLES=2, CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_flush_ctrl;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  branch_flush_ctrl_if #(.CNT_W(4)) bus_if ();

  branch_flush_ctrl #(
    .FLUSH_CYCLES (2),
    .CNT_W        (4)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_if)
  );

  // {stall_f, stall_d, flush_d, flush_e}
  logic [3:0] ctrl;
  assign ctrl = {bus_if.stall_f, bus_if.stall_d, bus_if.flush_d, bus_if.flush_e};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Lands 2 time units after the rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic taken_branch();
    bus_if.branch_d = 1'b1;
    tick();
    bus_if.branch_d = 1'b0;
    bus_if.pc_src_e = 1'b1;
    tick();
    bus_if.pc_src_e = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    bus_if.branch_d  = 1'b0;
    bus_if.flag_wr_e = 1'b0;
    bus_if.pc_src_e  = 1'b0;
    bus_if.vec_busy  = 1'b0;
    bus_if.clr_stats = 1'b0;

    // Reset
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_state", 32'(bus_if.state), 32'h0);
    chk("rst_ctrl",  32'(ctrl),         32'h0);
    chk("rst_total", 32'(bus_if.br_total), 32'h0);
    chk("rst_taken", 32'(bus_if.br_taken), 32'h0);

    // Not-taken branch: 0,2,0
    bus_if.branch_d = 1'b1;
    #1;
    chk("nt_ctrl_run", 32'(ctrl), 32'h0);
    tick();
    chk("nt_state_res", 32'(bus_if.state), 32'h2);
    bus_if.branch_d = 1'b0;
    bus_if.pc_src_e = 1'b0;
    #1;
    chk("nt_ctrl_res", 32'(ctrl), 32'h0);
    tick();
    chk("nt_state_run", 32'(bus_if.state), 32'h0);
    chk("nt_total", 32'(bus_if.br_total), 32'h1);
    chk("nt_taken", 32'(bus_if.br_taken), 32'h0);

    // Flag hazard + taken: 0,1,2,3,0
    bus_if.branch_d  = 1'b1;
    bus_if.flag_wr_e = 1'b1;
    #1;
    chk("hz_ctrl_run", 32'(ctrl), 32'hD);
    tick();
    chk("hz_state_hold", 32'(bus_if.state), 32'h1);
    bus_if.branch_d  = 1'b0;
    bus_if.flag_wr_e = 1'b0;
    #1;
    chk("hz_ctrl_hold", 32'(ctrl), 32'h0);
    tick();
    chk("hz_state_res", 32'(bus_if.state), 32'h2);
    bus_if.pc_src_e = 1'b1;
    #1;
    chk("hz_ctrl_res", 32'(ctrl), 32'h3);
    tick();
    chk("hz_state_flush", 32'(bus_if.state), 32'h3);
    bus_if.pc_src_e = 1'b0;
    #1;
    chk("hz_ctrl_flush", 32'(ctrl), 32'h3);
    tick();
    chk("hz_state_run", 32'(bus_if.state), 32'h0);
    chk("hz_ctrl_after", 32'(ctrl), 32'h0);
    chk("hz_total", 32'(bus_if.br_total), 32'h2);
    chk("hz_taken", 32'(bus_if.br_taken), 32'h1);

    // Vector busy overrides a branch in RUN
    bus_if.vec_busy  = 1'b1;
    bus_if.branch_d  = 1'b1;
    bus_if.flag_wr_e = 1'b1;
    #1;
    chk("vb_run_ctrl", 32'(ctrl), 32'hC);
    tick();
    chk("vb_run_state", 32'(bus_if.state), 32'h0);
    bus_if.vec_busy  = 1'b0;
    bus_if.flag_wr_e = 1'b0;

    // Vector busy while resolving
    tick();
    chk("vb_state_res", 32'(bus_if.state), 32'h2);
    bus_if.branch_d = 1'b0;
    bus_if.vec_busy = 1'b1;
    bus_if.pc_src_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("vb_ctrl_%0d", i), 32'(ctrl), 32'hC);
      tick();
      chk($sformatf("vb_state_%0d", i), 32'(bus_if.state), 32'h2);
      chk($sformatf("vb_total_%0d", i), 32'(bus_if.br_total), 32'h2);
    end
    bus_if.vec_busy = 1'b0;
    #1;
    chk("vb_rel_ctrl", 32'(ctrl), 32'h3);
    tick();
    chk("vb_rel_state", 32'(bus_if.state), 32'h3);
    chk("vb_rel_total", 32'(bus_if.br_total), 32'h3);
    chk("vb_rel_taken", 32'(bus_if.br_taken), 32'h2);
    bus_if.pc_src_e = 1'b0;
    tick();
    chk("vb_end_state", 32'(bus_if.state), 32'h0);

    // Saturation: 3+17 and 2+17 both clamp to 15
    for (int i = 0; i < 17; i++) begin
      taken_branch();
    end
    chk("sat_state", 32'(bus_if.state), 32'h0);
    chk("sat_total", 32'(bus_if.br_total), 32'hF);
    chk("sat_taken", 32'(bus_if.br_taken), 32'hF);

    // Clear coinciding with a taken resolve
    bus_if.branch_d = 1'b1;
    tick();
    bus_if.branch_d  = 1'b0;
    bus_if.pc_src_e  = 1'b1;
    bus_if.clr_stats = 1'b1;
    tick();
    chk("clr_state", 32'(bus_if.state), 32'h3);
    chk("clr_total", 32'(bus_if.br_total), 32'h0);
    chk("clr_taken", 32'(bus_if.br_taken), 32'h0);
    bus_if.pc_src_e  = 1'b0;
    bus_if.clr_stats = 1'b0;
    tick();
    chk("clr_end_state", 32'(bus_if.state), 32'h0);

    // Reset in the first FLUSH cycle
    bus_if.branch_d = 1'b1;
    tick();
    bus_if.branch_d = 1'b0;
    bus_if.pc_src_e = 1'b1;
    tick();
    chk("rf_state_flush", 32'(bus_if.state), 32'h3);
    chk("rf_taken_pre", 32'(bus_if.br_taken), 32'h1);
    bus_if.pc_src_e = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rf_sync_state", 32'(bus_if.state), 32'h3);
    tick();
    chk("rf_state", 32'(bus_if.state), 32'h0);
    chk("rf_ctrl",  32'(ctrl), 32'h0);
    chk("rf_total", 32'(bus_if.br_total), 32'h0);
    chk("rf_taken", 32'(bus_if.br_taken), 32'h0);
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
